// File: rtl/o_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer in front of the shift register.
// Q/QV/LAST are registered, and back-to-back words stream with no idle cycle between them.
module o_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    output logic             Q,
    output logic             QV,
    output logic             LAST
);
    localparam int unsigned   CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hb_q, hb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             hf_q, hf_d;
    logic             q_q, q_d;
    logic             qv_q, qv_d;
    logic             last_q, last_d;
    logic             accept, load;

    // Position within the word -> bit index of the word, honouring the shift order.
    function automatic logic [CW-1:0] bit_idx(input logic [CW-1:0] c);
        return MSB_FIRST ? CNT_MAX - c : c;
    endfunction

    assign DR      = E & ~hf_q & ~R;
    assign accept  = DV & DR;
    assign cnt_inc = cnt_q + 1'b1;
    // A load happens from IDLE, or seamlessly at the end of the current word.
    assign load    = E & hf_q & ((state_q == StIdle) | (cnt_q == CNT_MAX));

    always_comb begin
        hb_d    = hb_q;
        hf_d    = hf_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        q_d     = q_q;
        qv_d    = qv_q;
        last_d  = last_q;

        if (load) begin
            sr_d    = hb_q;
            hf_d    = 1'b0;
            cnt_d   = '0;
            state_d = StShift;
            q_d     = hb_q[bit_idx('0)];
            qv_d    = 1'b1;
            last_d  = 1'b0;
        end else if (E && (state_q == StShift)) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d  = cnt_inc;
                q_d    = sr_q[bit_idx(cnt_inc)];
                last_d = (cnt_inc == CNT_MAX);
            end else begin
                state_d = StIdle;
                cnt_d   = '0;
                q_d     = 1'b0;
                qv_d    = 1'b0;
                last_d  = 1'b0;
            end
        end

        // DR is low while HF is set, so this never collides with a load.
        if (accept) begin
            hb_d = D;
            hf_d = 1'b1;
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            hb_q    <= '0;
            hf_q    <= 1'b0;
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= StIdle;
            q_q     <= 1'b0;
            qv_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            hb_q    <= hb_d;
            hf_q    <= hf_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            last_q  <= last_d;
        end
    end

    assign Q    = q_q;
    assign QV   = qv_q;
    assign LAST = last_q;

endmodule

// File: tb/tb_o_serializer.sv
// Bench for o_serializer: a WIDTH=4 MSB-first and a WIDTH=10 LSB-first instance, each checked
// against a word-level model (hold slot + active word + bit position).
module tb_o_serializer;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] d0;
    logic [9:0] d1;
    logic [1:0] dv, dr, q, qv, last;

    always #5 clk = ~clk;

    o_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_dut0 (
        .C(clk), .R(rst), .E(en), .D(d0), .DV(dv[0]),
        .DR(dr[0]), .Q(q[0]), .QV(qv[0]), .LAST(last[0])
    );

    o_serializer #(.WIDTH(10), .MSB_FIRST(0)) u_dut1 (
        .C(clk), .R(rst), .E(en), .D(d1), .DV(dv[1]),
        .DR(dr[1]), .Q(q[1]), .QV(qv[1]), .LAST(last[1])
    );

    int unsigned wid[2] = '{4, 10};
    bit          msb[2] = '{1'b1, 1'b0};

    // Reference model
    bit          hold_v[2];
    int unsigned hold[2];
    bit          act_v[2];
    int unsigned act[2];
    int unsigned pos[2];
    int unsigned word[2];
    bit          acc[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_dr(input int i);
        return en && !rst && !hold_v[i];
    endfunction

    function automatic bit exp_q(input int i);
        int unsigned idx;
        if (!act_v[i]) return 1'b0;
        idx = msb[i] ? wid[i] - 1 - pos[i] : pos[i];
        return 1'((act[i] >> idx) & 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hold_v[i] = 1'b0;
            act_v[i]  = 1'b0;
            pos[i]    = 0;
        end
    endtask

    task automatic model_edge();
        if (rst || !en) return;
        for (int i = 0; i < 2; i++) begin
            if (act_v[i] && pos[i] < wid[i] - 1) begin
                pos[i]++;
            end else if (hold_v[i]) begin
                act_v[i]  = 1'b1;
                act[i]    = hold[i];
                pos[i]    = 0;
                hold_v[i] = 1'b0;
            end else begin
                act_v[i] = 1'b0;
            end
            if (acc[i]) begin
                hold_v[i] = 1'b1;
                hold[i]   = word[i];
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("q%0d", i), 32'(q[i]), 32'(exp_q(i)));
            check_eq($sformatf("qv%0d", i), 32'(qv[i]), 32'(act_v[i]));
            check_eq($sformatf("last%0d", i), 32'(last[i]),
                     32'(act_v[i] && pos[i] == wid[i] - 1));
            check_eq($sformatf("dr%0d", i), 32'(dr[i]), 32'(exp_dr(i)));
        end
    endtask

    // Inputs are driven on the falling edge; checks run just after, well before the rising edge.
    task automatic tick();
        #1;
        check_outputs();
        for (int i = 0; i < 2; i++) acc[i] = dv[i] && exp_dr(i);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 2; i++) if (acc[i]) dv[i] = 1'b0;
    endtask

    task automatic offer(input int i, input int unsigned w);
        word[i] = w;
        dv[i]   = 1'b1;
        if (i == 0) d0 = w[3:0];
        else d1 = w[9:0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dv  = '0;
        model_reset();
        #1;
        check_eq("rst_q", 32'(q[0]), 0);
        check_eq("rst_qv", 32'(qv[0]), 0);
        check_eq("rst_last", 32'(last[0]), 0);
        check_eq("rst_dr", 32'(dr), 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 14; k++) tick();
    endtask

    int unsigned bits[2];
    int          nbits[2];
    int          last_cnt[2];
    int          last_idx[2];
    int          gaps;
    bit          sent2;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        dv  = '0;
        d0  = '0;
        d1  = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // Reset holds everything low even with DV asserted
        dv = 2'b11;
        d0 = 4'hF;
        d1 = 10'h3FF;
        word[0] = 'hF;
        word[1] = 'h3FF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("reset_qv", 32'(qv), 0);
            check_eq("reset_dr", 32'(dr), 0);
        end
        dv  = '0;
        rst = 1'b0;
        tick();

        // Single word on both instances
        offer(0, 'hB);
        offer(1, 'h201);
        for (int i = 0; i < 2; i++) begin
            bits[i] = 0; nbits[i] = 0; last_cnt[i] = 0; last_idx[i] = -1;
        end
        for (int k = 0; k < 14; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (qv[i]) begin
                    bits[i] = (bits[i] << 1) | 32'(q[i]);
                    if (last[i]) begin
                        last_cnt[i]++;
                        last_idx[i] = nbits[i];
                    end
                    nbits[i]++;
                end
            end
        end
        check_eq("single4_bits", bits[0], 'b1011);
        check_eq("single4_n", nbits[0], 4);
        check_eq("single4_last_cnt", last_cnt[0], 1);
        check_eq("single4_last_idx", last_idx[0], 3);
        check_eq("single10_bits", bits[1], 'b1000000001);
        check_eq("single10_n", nbits[1], 10);
        check_eq("single10_last_cnt", last_cnt[1], 1);
        check_eq("single10_last_idx", last_idx[1], 9);
        check_eq("single_q_idle", 32'(q), 0);

        // Back-to-back A then 5
        offer(0, 'hA);
        sent2 = 1'b0; bits[0] = 0; nbits[0] = 0; gaps = 0;
        for (int k = 0; k < 20; k++) begin
            if (!dv[0] && !sent2) begin
                offer(0, 'h5);
                sent2 = 1'b1;
            end
            tick();
            if (qv[0]) begin
                bits[0] = (bits[0] << 1) | 32'(q[0]);
                nbits[0]++;
            end else if (nbits[0] > 0 && nbits[0] < 8) begin
                gaps++;
            end
        end
        check_eq("b2b_bits", bits[0], 'hA5);
        check_eq("b2b_n", nbits[0], 8);
        check_eq("b2b_gaps", gaps, 0);

        // Enable stall after the 2nd bit of C
        offer(0, 'hC);
        nbits[0] = 0;
        for (int k = 0; k < 10 && nbits[0] < 2; k++) begin
            tick();
            if (qv[0]) nbits[0]++;
        end
        check_eq("stall_reached", nbits[0], 2);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("stall_q", 32'(q[0]), 1);
            check_eq("stall_dr", 32'(dr[0]), 0);
        end
        en = 1'b1;
        tick();
        check_eq("resume_bit3", 32'(q[0]), 0);
        tick();
        check_eq("resume_bit4", 32'(q[0]), 0);
        check_eq("resume_last", 32'(last[0]), 1);
        drain();

        // Reset while the 3rd bit is out and a second word is held
        offer(0, 'h9);
        sent2 = 1'b0; nbits[0] = 0;
        for (int k = 0; k < 12 && nbits[0] < 3; k++) begin
            if (!dv[0] && !sent2) begin
                offer(0, 'h6);
                sent2 = 1'b1;
            end
            tick();
            if (qv[0]) nbits[0]++;
        end
        check_eq("midrst_reached", nbits[0], 3);
        check_eq("midrst_held", 32'(dr[0]), 0);
        do_reset();
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("midrst_silent", 32'(qv[0]), 0);
        end
        offer(0, 'h3);
        tick();
        drain();

        // Randomized traffic with occasional stalls and resets
        for (int k = 0; k < 600; k++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < 2; i++) begin
                if (!dv[i] && $urandom_range(0, 2) != 0)
                    offer(i, $urandom & ((1 << wid[i]) - 1));
            end
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/o_serializer.md
O_SERIALIZER -- requirements
Module: o_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width; legal range 2..10.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.
REQ-003 C  input  1: clock; all state updates on posedge C.
REQ-004 R  input  1: reset; asynchronous and active-high.
REQ-005 E  input  1: active-high clock enable; gates every state update.
REQ-006 D  input  WIDTH: parallel data word from the upstream register stage.
REQ-007 DV  input  1: D valid.
REQ-008 DR  output  1: ready to accept D.
REQ-009 Q  output  1: serial data, registered; feeds the downstream flop stage.
REQ-010 QV  output  1: Q carries a valid bit, registered.
REQ-011 LAST  output  1: Q carries the final bit of a word, registered.

Function
REQ-012 Internal state SHALL be: hold buffer HB (WIDTH bits) with flag HF; shift register SR (WIDTH bits); bit counter CNT (0..WIDTH-1); FSM state IDLE or SHIFT.
REQ-013 DR SHALL equal E & !HF, combinationally.
REQ-014 Accept SHALL occur on a posedge C with DV & DR high: HB <= D and HF <= 1.
REQ-015 When E is low, HB, HF, SR, CNT, the FSM state, Q, QV and LAST SHALL all hold their values.
REQ-016 Load: on an enabled edge in IDLE with HF=1, SR <= HB, HF <= 0, CNT <= 0, state <= SHIFT, Q <= first bit, QV <= 1.
REQ-017 Latency: a word accepted at enabled edge k SHALL present its first bit on Q after enabled edge k+1, provided the FSM is in IDLE at edge k+1.
REQ-018 In SHIFT with CNT < WIDTH-1, each enabled edge SHALL do CNT <= CNT+1 and Q <= next bit in MSB_FIRST order; QV stays 1.
REQ-019 LAST SHALL be 1 exactly while Q carries the bit for CNT = WIDTH-1.
REQ-020 Back-to-back: in SHIFT at CNT = WIDTH-1 with HF=1, the next enabled edge SHALL perform the REQ-016 load with no idle cycle, and the FSM SHALL remain in SHIFT.
REQ-021 Underrun: in SHIFT at CNT = WIDTH-1 with HF=0, the next enabled edge SHALL set state <= IDLE, QV <= 0, LAST <= 0 and Q <= 0.
REQ-022 An accept SHALL never occur on the same edge as a load, because DR is 0 while HF=1.
REQ-023 A new accept SHALL be possible on the edge after a load; sustained throughput SHALL be one word per WIDTH enabled cycles.
REQ-024 While HF=1, a DV without an accept SHALL be ignored; upstream holds D and DV until DR is 1.
REQ-025 While QV=0, Q SHALL be 0.

Reset
REQ-026 While R=1, the block SHALL asynchronously force: Q=0, QV=0, LAST=0, HF=0, CNT=0, SR=0, HB=0, state IDLE.
REQ-027 DR SHALL be 0 while R=1.
REQ-028 R asserted mid-word SHALL discard the word in flight and any held word.
REQ-029 After R deasserts, the first enabled edge SHALL be able to accept.

Verification (WIDTH=4, MSB_FIRST=1 unless stated)
REQ-030 Reset: assert R, toggle C, drive DV=1 -> Q=0, QV=0, LAST=0, DR=0 throughout.
REQ-031 Single word: D=4'b1011, DV=1 for one edge -> one edge later Q sequence 1,0,1,1 with QV=1; LAST=1 on the 4th bit only; then QV=0, Q=0.
REQ-032 Back-to-back: words 4'hA then 4'h5, each offered as soon as DR=1 -> Q=1,0,1,0,0,1,0,1 contiguous; QV never drops between words.
REQ-033 Enable stall: E=0 for 3 cycles after the 2nd bit of 4'hC -> Q frozen at 1 and DR=0 during the stall; serialization resumes with 0,0.
REQ-034 Mid-word reset: raise R while the 3rd bit is on Q, with a held word pending -> outputs zero immediately; no bits emitted after release until a new accept.
REQ-035 MSB_FIRST=0, WIDTH=10: D=10'h201 -> Q=1,0,0,0,0,0,0,0,0,1; LAST on the 10th bit only.
